prco_btn_debounce: RTL and testbench
====================================

// Module: prco_btn_debounce
// PURPOSE
//  Conditions the raw PORTC3 pushbutton pin before the xc6lx9_msp top-level core logic.
//  - Synchronises the asynchronous pin into the clk50 domain.
//  - Rejects bounce and glitches shorter than STABLE_CYCLES.
//  - Outputs a clean level plus single-cycle rise/fall strobes (step/run/irq request to core).
// PARAMETERS
//  SYNC_STAGES    2       flops in input synchroniser (>=2)
//  STABLE_CYCLES  50000   consecutive clk50 cycles input must hold new value (1 ms @ 50 MHz)
//  CNT_W          16      stability counter width; 2**CNT_W > STABLE_CYCLES
//  HOLD_CYCLES    50000000 cycles of debounced-high before btn_hold (only with BTN_HOLD_EN)
// PORTS
//  clk50      in   1   50 MHz system clock, all logic rising-edge
//  rst_n      in   1   asynchronous active-low reset
//  btn_in     in   1   raw pin (PORTC3), asynchronous, may bounce
//  btn_level  out  1   debounced level
//  btn_rise   out  1   one-cycle strobe, debounced 0->1
//  btn_fall   out  1   one-cycle strobe, debounced 1->0
//  btn_hold   out  1   one-cycle strobe, long press (tied 0 without BTN_HOLD_EN)
// BEHAVIOUR
//  Reset values
//  - On rst_n=0: sync chain=0, state=S_LO, counter=0, all outputs 0.
//  - Reset is asynchronous; release is sampled on clk50.
//  Synchroniser
//  - s = last synchroniser stage, SYNC_STAGES cycles behind btn_in.
//  FSM states
//  - S_LO: steady low. If s=1, go to S_WAIT_HI, cnt<=0.
//  - S_WAIT_HI: if s=0, go to S_LO, cnt<=0 (glitch rejected).
//      Else if cnt==STABLE_CYCLES-1, go to S_HI, btn_level<=1, btn_rise<=1.
//      Else cnt<=cnt+1.
//  - S_HI: steady high. If s=0, go to S_WAIT_LO, cnt<=0.
//  - S_WAIT_LO: mirror of S_WAIT_HI, ending in S_HI->S_LO; btn_level<=0, btn_fall<=1.
//  Latency
//  - A clean edge on btn_in changes btn_level exactly SYNC_STAGES+STABLE_CYCLES+1 clk50 cycles later.
//  - Strobe asserts in the same cycle as the btn_level change and deasserts the next cycle.
//  Boundary conditions
//  - Any reversion of s during a WAIT state restarts the qualification from zero; there is no partial credit.
//  - btn_rise and btn_fall are never high together; at most one strobe per STABLE_CYCLES window.
//  - cnt saturates structurally: it is never incremented past STABLE_CYCLES-1.
//  - rst_n asserted mid-WAIT: returns to S_LO immediately with no strobe.
//      If the pin is held high through reset release, a rise is reported after full latency.
//  - Outputs are registered; no combinational path from btn_in to any output.
// CONFIGURATION
//  BTN_HOLD_EN defined
//  - Second counter hcnt (width sized for HOLD_CYCLES) clears on every entry to S_HI.
//  - hcnt increments while in S_HI and stops at HOLD_CYCLES-1.
//  - btn_hold pulses for one cycle when hcnt reaches HOLD_CYCLES-1; at most once per press.
//  - Leaving S_HI clears hcnt.
//  BTN_HOLD_EN undefined
//  - No hcnt logic; btn_hold is constant 0; HOLD_CYCLES is ignored.
// TESTING
//  Bench uses STABLE_CYCLES=8, SYNC_STAGES=2, HOLD_CYCLES=32; clk50 period 20 ns.
//  1. Reset: rst_n=0 with btn_in=1 -> all outputs 0.
//     Release -> btn_level=1 and btn_rise pulse exactly 11 cycles later.
//  2. Clean press: btn_in 0->1, held 20 cycles -> btn_rise high for 1 cycle at edge+11, btn_level=1 thereafter.
//  3. Bounce: btn_in toggles 1,0,1 at one-cycle spacing, then holds 1 -> single btn_rise
//     at last edge+11; no btn_fall.
//  4. Glitch: btn_in=1 for 5 cycles, then 0 -> btn_level stays 0, no strobes.
//  5. Release mid-qualification: rst_n pulsed low 3 cycles into S_WAIT_LO -> outputs 0 at once, no btn_fall.
//  6. BTN_HOLD_EN: press held 60 cycles -> one btn_hold pulse at 32 cycles after btn_rise, none after.
//     Without the macro, btn_hold stays 0.

Source files
------------

// File: rtl/prco_btn_debounce_if.sv
// Pushbutton conditioning bundle: raw pin in, debounced level and strobes out.
interface prco_btn_debounce_if;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_hold;

  modport master (output btn_in, input btn_level, btn_rise, btn_fall, btn_hold);
  modport slave  (input btn_in, output btn_level, btn_rise, btn_fall, btn_hold);
endinterface

// File: rtl/prco_btn_debounce.sv
// PORTC3 pushbutton synchroniser + debouncer with registered level and edge strobes.
// Optional long-press strobe btn_hold is built only when BTN_HOLD_EN is defined.
module prco_btn_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned HOLD_CYCLES   = 50000000
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  prco_btn_debounce_if.slave    btn
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {S_LO, S_WAIT_HI, S_HI, S_WAIT_LO} state_t;

  // Reject parameter sets the counters cannot represent.
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || (STABLE_CYCLES >> CNT_W) != 0 ||
      HOLD_CYCLES < 2) begin : g_param_err
    $error("prco_btn_debounce: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn.btn_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any reversion during a WAIT state restarts qualification from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LO: begin
        if (s) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!s) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!s) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end
      end
      S_WAIT_LO: begin
        if (s) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn.btn_level = level_q;
  assign btn.btn_rise  = rise_q;
  assign btn.btn_fall  = fall_q;

`ifdef BTN_HOLD_EN
  localparam int unsigned      HCNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
      done_q <= done_d;
    end
  end

  // hcnt runs only while steadily high; done_q limits the strobe to once per press.
  always_comb begin
    hcnt_d = '0;
    hold_d = 1'b0;
    done_d = done_q;
    if (state_q == S_HI) begin
      hcnt_d = (hcnt_q == HCNT_LAST) ? hcnt_q : hcnt_q + HCNT_W'(1);
      if (hcnt_q == HCNT_LAST && !done_q) begin
        hold_d = 1'b1;
        done_d = 1'b1;
      end
    end else if (state_q == S_LO) begin
      done_d = 1'b0;
    end
  end

  assign btn.btn_hold = hold_q;
`else
  assign btn.btn_hold = 1'b0;
`endif

endmodule

// File: tb/tb_prco_btn_debounce.sv
// Randomised + directed bench for prco_btn_debounce against a run-length reference model.
module tb_prco_btn_debounce;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 8;
  localparam int unsigned HOLD   = 32;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;

  prco_btn_debounce_if btn_if ();

  prco_btn_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (4),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk50(clk50),
    .rst_n(rst_n),
    .btn  (btn_if)
  );

  always #10 clk50 = ~clk50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin delayed SYNC edges, level flips after STABLE+1 consecutive differing samples.
  bit pipe[$];
  bit m_level, m_done, e_rise, e_fall, e_hold;
  int m_run, m_age;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < int'(SYNC); i++) pipe.push_back(1'b0);
    m_level = 0; m_run = 0; m_age = 0; m_done = 0;
    e_rise = 0; e_fall = 0; e_hold = 0;
  endtask

  task automatic model_edge(input bit b, input bit r);
    bit s, steady_hi;
    if (!r) begin
      model_reset();
      return;
    end
    s = pipe.pop_front();
    pipe.push_back(b);
    steady_hi = m_level && (m_run == 0);
    e_rise = 0; e_fall = 0; e_hold = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == int'(STABLE) + 1) begin
        m_level = s;
        m_run   = 0;
        if (s) e_rise = 1; else e_fall = 1;
      end
    end else begin
      m_run = 0;
    end
`ifdef BTN_HOLD_EN
    m_age = steady_hi ? m_age + 1 : 0;
    if (m_age == int'(HOLD) && !m_done) begin
      e_hold = 1;
      m_done = 1;
    end
    if (!m_level) m_done = 0;
`else
    m_age = steady_hi ? 0 : 0;
`endif
  endtask

  int cyc_no = 0;
  int n_rise = 0, n_fall = 0, n_hold = 0;
  int rise_at = 0, fall_at = 0, hold_at = 0;

  task automatic compare_all(input string tag);
    check({tag, "_level"}, int'(btn_if.btn_level), int'(m_level));
    check({tag, "_rise"},  int'(btn_if.btn_rise),  int'(e_rise));
    check({tag, "_fall"},  int'(btn_if.btn_fall),  int'(e_fall));
    check({tag, "_hold"},  int'(btn_if.btn_hold),  int'(e_hold));
  endtask

  // One clock: drive inputs now (just after an edge), model the next edge, sample 1 ns after it.
  task automatic cyc(input bit b, input bit r, input string tag);
    btn_if.btn_in = b;
    rst_n = r;
    @(posedge clk50);
    model_edge(b, r);
    #1;
    cyc_no++;
    if (btn_if.btn_rise) begin n_rise++; rise_at = cyc_no; end
    if (btn_if.btn_fall) begin n_fall++; fall_at = cyc_no; end
    if (btn_if.btn_hold) begin n_hold++; hold_at = cyc_no; end
    compare_all(tag);
  endtask

  task automatic clr_counts();
    n_rise = 0; n_fall = 0; n_hold = 0;
    rise_at = 0; fall_at = 0; hold_at = 0;
  endtask

  int start;

  initial begin
    btn_if.btn_in = 1'b1;
    model_reset();
    #1;
    // 1: reset with pin high, then a full-latency rise after release
    compare_all("t1_inrst");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "t1_rst");
    clr_counts();
    start = cyc_no + 1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, "t1");
    check("t1_rise_cnt", n_rise, 1);
    check("t1_rise_lat", rise_at - start + 1, 11);

    // 2: clean release then clean press
    clr_counts();
    start = cyc_no + 1;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "t2r");
    check("t2_fall_lat", fall_at - start + 1, 11);
    clr_counts();
    start = cyc_no + 1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, "t2p");
    check("t2_rise_lat", rise_at - start + 1, 11);
    check("t2_level", int'(btn_if.btn_level), 1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "t2z");

    // 3: bounce 1,0,1 then hold high
    clr_counts();
    cyc(1'b1, 1'b1, "t3");
    cyc(1'b0, 1'b1, "t3");
    start = cyc_no + 1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, "t3");
    check("t3_rise_cnt", n_rise, 1);
    check("t3_fall_cnt", n_fall, 0);
    check("t3_rise_lat", rise_at - start + 1, 11);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "t3z");

    // 4: five-cycle glitch is rejected
    clr_counts();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, "t4");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "t4");
    check("t4_rise_cnt", n_rise, 0);
    check("t4_level", int'(btn_if.btn_level), 0);

    // 5: reset three cycles into S_WAIT_LO
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, "t5p");
    clr_counts();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, "t5w");
    check("t5_level_pre", int'(btn_if.btn_level), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("t5_async");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, "t5_rst");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "t5");
    check("t5_fall_cnt", n_fall, 0);

    // 6: long press
    clr_counts();
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, "t6");
    check("t6_rise_cnt", n_rise, 1);
`ifdef BTN_HOLD_EN
    check("t6_hold_cnt", n_hold, 1);
    check("t6_hold_lat", hold_at - rise_at, 32);
`else
    check("t6_hold_cnt", n_hold, 0);
`endif
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "t6z");

    // Random bouncy segments with occasional resets
    for (int seg = 0; seg < 220; seg++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(9, 45)) : int'($urandom_range(1, 12));
      if ($urandom_range(0, 29) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) cyc(v, 1'b0, "rnd_rst");
      end
      for (int i = 0; i < len; i++) cyc(v, 1'b1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
